// File: rtl/rx_frame_packer.sv
// Packs radio RX frames into 16-bit SRAM words: sync 0x2DD4, {len,d0}, data pairs.
// Frames that are empty, oversize or too large for free SRAM space are dropped whole.
module rx_frame_packer #(
  parameter int MAX_LEN          = 64,
  parameter int SRAM_DEPTH_WORDS = 262144
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  output logic        rx_ready,
  output logic        SRAM_write,
  output logic [15:0] Data_to_sram,
  input  logic        SRAM_hint,
  input  logic        SRAM_full,
  input  logic [17:0] SRAM_count,
  output logic        Pkt_Received_int,
  output logic [7:0]  drop_count,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, CHECK, WR_SYNC, GET_D0, WR_WORD, GET_HI, GET_LO, DONE, DISCARD
  } state_t;

  localparam logic [15:0] SYNC_WORD = 16'h2DD4;
  // Depth may be exactly 2^18, so free-space math needs one extra bit.
  localparam logic [18:0] DEPTH     = 19'(SRAM_DEPTH_WORDS);
  localparam logic [7:0]  MAX_L     = 8'(MAX_LEN);

  state_t      state, state_next;
  logic [7:0]  len_q, rem_q;
  logic [15:0] word_q;
  logic        accept, write_done, drop_inc, fits;
  logic [18:0] need, free;

  assign rx_ready = (state == IDLE) || (state == GET_D0) || (state == GET_HI) ||
                    (state == GET_LO) || (state == DISCARD);
  assign accept     = rx_valid & rx_ready;
  assign write_done = SRAM_write & SRAM_hint;

  assign need = 19'd2 + 19'(len_q[7:1]);
  assign free = ({1'b0, SRAM_count} >= DEPTH) ? 19'd0 : (DEPTH - {1'b0, SRAM_count});
  assign fits = (free >= need);

  assign Pkt_Received_int = (state == DONE);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && rx_sop) begin
          if (rx_data == 8'd0) begin
            drop_inc = 1'b1;
          end else if (rx_data > MAX_L) begin
            drop_inc   = 1'b1;
            state_next = DISCARD;
          end else begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (fits) begin
          state_next = WR_SYNC;
        end else begin
          drop_inc   = 1'b1;
          state_next = DISCARD;
        end
      end
      WR_SYNC: if (write_done) state_next = GET_D0;
      GET_D0:  if (accept) state_next = WR_WORD;
      WR_WORD: if (write_done) state_next = (rem_q == 8'd0) ? DONE : GET_HI;
      GET_HI:  if (accept) state_next = (rem_q == 8'd1) ? WR_WORD : GET_LO;
      GET_LO:  if (accept) state_next = WR_WORD;
      DONE:    state_next = IDLE;
      DISCARD: if (rem_q == 8'd0 || (accept && rem_q == 8'd1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q  <= '0;
      rem_q  <= '0;
      word_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept && rx_sop) begin
          len_q <= rx_data;
          rem_q <= rx_data;
        end
        GET_D0: if (accept) begin
          word_q <= {len_q, rx_data};
          rem_q  <= len_q - 8'd1;
        end
        GET_HI: if (accept) begin
          word_q[15:8] <= rx_data;
          if (rem_q == 8'd1) word_q[7:0] <= 8'h00;
          rem_q <= rem_q - 8'd1;
        end
        GET_LO: if (accept) begin
          word_q[7:0] <= rx_data;
          rem_q       <= rem_q - 8'd1;
        end
        DISCARD: if (accept && rem_q != 8'd0) rem_q <= rem_q - 8'd1;
        default: ;
      endcase
    end
  end

  // Write launches only while not full; once launched it is held until the hint.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SRAM_write   <= 1'b0;
      Data_to_sram <= '0;
    end else if (state == WR_SYNC || state == WR_WORD) begin
      if (!SRAM_write && !SRAM_full) begin
        SRAM_write   <= 1'b1;
        Data_to_sram <= (state == WR_SYNC) ? SYNC_WORD : word_q;
      end else if (write_done) begin
        SRAM_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          drop_count <= '0;
    else if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

endmodule
